// File: rtl/result_drain.sv
// -----------------------------------------------------------------------------
// result_drain
//
// Drains the systolic-array output buffer at the end of a pass. On an accepted
// start pulse the block issues ROWS row reads (buf_rd_en), captures the rows
// that come back RD_LAT cycles later into a small show-ahead FIFO, and streams
// them downstream over valid/ready with m_last on the final row. Reads are only
// issued while a FIFO slot is guaranteed for the returning data, so downstream
// backpressure stalls the reads instead of losing rows.
//
// Ports
//   clk         : clock, all state changes on the rising edge
//   rst         : synchronous reset, active low
//   start       : one-cycle pulse starting a pass (honoured only when idle)
//   buf_rd_en   : output-buffer read strobe, one row per high cycle
//   buf_rd_data : row returned RD_LAT cycles after its strobe
//   m_valid     : downstream valid (FIFO not empty)
//   m_ready     : downstream ready
//   m_data      : head-of-FIFO row, row 0 first; zero while m_valid is low
//   m_last      : marks row ROWS-1
//   busy        : high while reading or flushing
//   done        : one-cycle pulse when the last row has been accepted
// -----------------------------------------------------------------------------
module result_drain #(
  parameter int ROWS       = 4,   // ARRAYHEIGHT of the reference array
  parameter int ROW_W      = 32,  // OUTPUT_BUF_DATASIZE (8) * ARRAYWIDTH (4)
  parameter int RD_LAT     = 1,   // 1..4
  parameter int FIFO_DEPTH = 4    // must be >= RD_LAT + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             buf_rd_en,
  input  logic [ROW_W-1:0] buf_rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ROW_W-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done
);

  localparam int RC_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = OCC_W + 1;

  localparam logic [RC_W-1:0]  LAST_ROW  = RC_W'(ROWS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q,       state_d;
  logic [RC_W-1:0]    issue_cnt_q,   issue_cnt_d;
  logic [RC_W-1:0]    beat_cnt_q,    beat_cnt_d;
  logic [RD_LAT-1:0]  pipe_q,        pipe_d;
  logic [OCC_W-1:0]   outstanding_q, outstanding_d;
  logic [OCC_W-1:0]   occ_q,         occ_d;
  logic [PTR_W-1:0]   wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,      rd_ptr_d;
  logic [ROW_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ROW_W-1:0]   mem_d [FIFO_DEPTH];

  logic               issue_ok;
  logic               wr_en;
  logic               pop;
  logic [SUM_W-1:0]   credit_sum;

  // Circular FIFO pointer increment for any depth, power of two or not.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Read credit, FIFO write/pop strobes and the returned-data pipeline.
  always_comb begin
    // Only registered terms feed the credit check, so a pop in this cycle
    // frees its slot for the next cycle, never for the current one.
    credit_sum = SUM_W'(outstanding_q) + SUM_W'(occ_q);
    issue_ok   = (state_q == S_ISSUE) && (credit_sum < DEPTH_SUM);
    wr_en      = pipe_q[RD_LAT-1];
    pop        = (occ_q != {OCC_W{1'b0}}) && m_ready;

    pipe_d    = {RD_LAT{1'b0}};
    pipe_d[0] = issue_ok;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Credit counters and FIFO storage/pointers.
  always_comb begin
    outstanding_d = outstanding_q;
    occ_d         = occ_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mem_d         = mem_q;

    case ({issue_ok, wr_en})
      2'b10:   outstanding_d = outstanding_q + OCC_W'(1);
      2'b01:   outstanding_d = outstanding_q - OCC_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // Simultaneous write and pop leaves the count unchanged; the pointers
    // still move independently so ordering is preserved.
    case ({wr_en, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (wr_en) begin
      mem_d[wr_ptr_q] = buf_rd_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pass sequencing: state, issue counter and beat counter.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;

    if (pop) begin
      if (beat_cnt_q == LAST_ROW) begin
        beat_cnt_d = {RC_W{1'b0}};
      end else begin
        beat_cnt_d = beat_cnt_q + RC_W'(1);
      end
    end else begin
      beat_cnt_d = beat_cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ISSUE;
          issue_cnt_d = {RC_W{1'b0}};
          beat_cnt_d  = {RC_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (issue_ok) begin
          if (issue_cnt_q == LAST_ROW) begin
            state_d = S_FLUSH;
          end else begin
            issue_cnt_d = issue_cnt_q + RC_W'(1);
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_FLUSH: begin
        // The final row always pops in FLUSH: its data returns at least
        // RD_LAT+1 cycles after the last read was issued.
        if (pop && m_last) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset drops any rows
  // still in flight from the output buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      issue_cnt_q   <= {RC_W{1'b0}};
      beat_cnt_q    <= {RC_W{1'b0}};
      pipe_q        <= {RD_LAT{1'b0}};
      outstanding_q <= {OCC_W{1'b0}};
      occ_q         <= {OCC_W{1'b0}};
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {ROW_W{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      issue_cnt_q   <= issue_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      pipe_q        <= pipe_d;
      outstanding_q <= outstanding_d;
      occ_q         <= occ_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // All outputs are decoded from registered state only.
  assign buf_rd_en = issue_ok;
  assign m_valid   = (occ_q != {OCC_W{1'b0}});
  assign m_data    = m_valid ? mem_q[rd_ptr_q] : {ROW_W{1'b0}};
  assign m_last    = m_valid && (beat_cnt_q == LAST_ROW);
  assign busy      = (state_q == S_ISSUE) || (state_q == S_FLUSH);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_result_drain.sv
// -----------------------------------------------------------------------------
// tb_result_drain
//
// Three instances of result_drain, each with its own output-buffer model:
//   u_a : ROWS=4, RD_LAT=1, FIFO_DEPTH=4  (nominal, ignored starts,
//         backpressure, mid-pass reset)
//   u_b : ROWS=8, RD_LAT=3, FIFO_DEPTH=5  (credit stall, random ready)
//   u_c : ROWS=1, RD_LAT=1, FIFO_DEPTH=3  (single-row pass)
// Outputs are sampled on the falling edge; inputs change right after sampling.
// -----------------------------------------------------------------------------
module tb_result_drain;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         start_a, rd_en_a, m_valid_a, m_ready_a, m_last_a, busy_a, done_a;
  logic [W-1:0] rd_data_a, m_data_a;
  logic         start_b, rd_en_b, m_valid_b, m_ready_b, m_last_b, busy_b, done_b;
  logic [W-1:0] rd_data_b, m_data_b;
  logic         start_c, rd_en_c, m_valid_c, m_ready_c, m_last_c, busy_c, done_c;
  logic [W-1:0] rd_data_c, m_data_c;

  result_drain #(.ROWS(4), .ROW_W(W), .RD_LAT(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .buf_rd_en(rd_en_a),
    .buf_rd_data(rd_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
    .m_data(m_data_a), .m_last(m_last_a), .busy(busy_a), .done(done_a));

  result_drain #(.ROWS(8), .ROW_W(W), .RD_LAT(3), .FIFO_DEPTH(5)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .buf_rd_en(rd_en_b),
    .buf_rd_data(rd_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
    .m_data(m_data_b), .m_last(m_last_b), .busy(busy_b), .done(done_b));

  result_drain #(.ROWS(1), .ROW_W(W), .RD_LAT(1), .FIFO_DEPTH(3)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .buf_rd_en(rd_en_c),
    .buf_rd_data(rd_data_c), .m_valid(m_valid_c), .m_ready(m_ready_c),
    .m_data(m_data_c), .m_last(m_last_c), .busy(busy_c), .done(done_c));

  // control bundles {buf_rd_en, m_valid, m_last, done, busy}
  logic [4:0] ctl_a, ctl_b, ctl_c;
  assign ctl_a = {rd_en_a, m_valid_a, m_last_a, done_a, busy_a};
  assign ctl_b = {rd_en_b, m_valid_b, m_last_b, done_b, busy_b};
  assign ctl_c = {rd_en_c, m_valid_c, m_last_c, done_c, busy_c};

  logic [7:0] tag_a, tag_b, tag_c;
  int idx_a, idx_b, idx_c;
  logic [W-1:0] dly_a [1];
  logic [W-1:0] dly_b [3];
  logic [W-1:0] dly_c [1];

  // Row contents for the 4-row and 1-row buffers: low byte 0x11,0x22,...
  function automatic logic [W-1:0] row_a(input logic [7:0] tag, input int idx);
    logic [7:0] lo;
    lo = 8'((idx + 1) * 17);
    return {tag, 16'h0000, lo};
  endfunction

  // Row contents for the 8-row buffer.
  function automatic logic [W-1:0] row_b(input logic [7:0] tag, input int idx);
    return {tag, 8'hB0, 16'(idx)};
  endfunction

  // Output-buffer models: auto-incrementing row index, fixed read latency,
  // junk on the data bus whenever no read is returning.
  always @(posedge clk) begin
    if (!rst) idx_a <= 0;
    else if (start_a && !busy_a && !done_a) idx_a <= 0;
    else if (rd_en_a) idx_a <= idx_a + 1;
    dly_a[0] <= rd_en_a ? row_a(tag_a, idx_a) : 32'hDEAD_BEEF;

    if (!rst) idx_c <= 0;
    else if (start_c && !busy_c && !done_c) idx_c <= 0;
    else if (rd_en_c) idx_c <= idx_c + 1;
    dly_c[0] <= rd_en_c ? row_a(tag_c, idx_c) : 32'hDEAD_BEEF;

    if (!rst) idx_b <= 0;
    else if (start_b && !busy_b && !done_b) idx_b <= 0;
    else if (rd_en_b) idx_b <= idx_b + 1;
    dly_b[0] <= rd_en_b ? row_b(tag_b, idx_b) : 32'hDEAD_BEEF;
    for (int i = 1; i < 3; i++) dly_b[i] <= dly_b[i-1];
  end

  assign rd_data_a = dly_a[0];
  assign rd_data_b = dly_b[2];
  assign rd_data_c = dly_c[0];

  int total = 0;
  int bad   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hand-derived trace for a 4-row pass, RD_LAT=1, m_ready=1, start in k=0.
  logic [4:0] nom_vec [9] = '{5'b00000, 5'b10001, 5'b10001, 5'b11001, 5'b11001,
                              5'b01001, 5'b01101, 5'b00010, 5'b00000};
  logic [7:0] nom_lo  [9] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22,
                              8'h33, 8'h44, 8'h00, 8'h00};

  // Hand-derived trace for the 1-row pass.
  logic [4:0] one_vec [6] = '{5'b00000, 5'b10001, 5'b00001, 5'b01101, 5'b00010, 5'b00000};

  task automatic run_nom_a(input string name, input logic [8:0] start_mask, input int abort_at);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk_eq($sformatf("%s_ctl_k%0d", name, k), 64'(ctl_a), 64'(nom_vec[k]));
      if (nom_vec[k][3]) chk_eq($sformatf("%s_data_k%0d", name, k), 64'(m_data_a),
                                64'({tag_a, 16'h0000, nom_lo[k]}));
      start_a = start_mask[k];
      if (k == abort_at) begin
        rst = 1'b0;
        break;
      end
    end
    start_a = 1'b0;
  endtask

  // One pass on u_b. mode 0: ready=1, 1: random ready, 2: scripted credit stall.
  task automatic pass_b(input string name, input int mode);
    int reads, beats, lasts;
    logic got_done, prev_hold;
    logic [W-1:0] prev_data;
    reads = 0; beats = 0; lasts = 0;
    got_done = 1'b0; prev_hold = 1'b0; prev_data = '0;
    for (int k = 0; k < 400 && !got_done; k++) begin
      @(negedge clk);
      if (prev_hold) chk_eq({name, "_hold"}, 64'(m_data_b), 64'(prev_data));
      if (rd_en_b) reads++;
      if (mode == 2 && k == 15) chk_eq({name, "_stall_reads"}, 64'(reads), 64'd5);
      if (mode == 2 && k >= 16 && k <= 18)
        chk_eq($sformatf("%s_resume_k%0d", name, k), 64'(rd_en_b), 64'(k == 17));
      start_b = (k == 0);
      case (mode)
        0:       m_ready_b = 1'b1;
        1:       m_ready_b = 1'($urandom_range(1, 0));
        default: m_ready_b = (k == 16) || (k >= 20);
      endcase
      if (m_valid_b && m_ready_b) begin
        chk_eq($sformatf("%s_data%0d", name, beats), 64'(m_data_b), 64'(row_b(tag_b, beats)));
        chk_eq($sformatf("%s_last%0d", name, beats), 64'(m_last_b), 64'(beats == 7));
        if (m_last_b) lasts++;
        beats++;
      end
      prev_hold = m_valid_b && !m_ready_b;
      prev_data = m_data_b;
      if (done_b) got_done = 1'b1;
    end
    start_b = 1'b0;
    chk_eq({name, "_reads"}, 64'(reads), 64'd8);
    chk_eq({name, "_beats"}, 64'(beats), 64'd8);
    chk_eq({name, "_lasts"}, 64'(lasts), 64'd1);
    chk_eq({name, "_done"},  64'(got_done), 64'd1);
  endtask

  int cnt, n;
  logic got_done;

  initial begin
    rst = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    m_ready_a = 1'b1; m_ready_b = 1'b1; m_ready_c = 1'b1;
    tag_a = 8'h00; tag_b = 8'h00; tag_c = 8'h00;

    repeat (3) @(negedge clk);
    chk_eq("rst_ctl_a", 64'(ctl_a), 64'd0);
    chk_eq("rst_data_a", 64'(m_data_a), 64'd0);
    chk_eq("rst_ctl_b", 64'(ctl_b), 64'd0);
    chk_eq("rst_ctl_c", 64'(ctl_c), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // nominal 4-row pass
    run_nom_a("nom", 9'b000000001, -1);

    // starts in ISSUE (k2), FLUSH (k5) and DONE (k7) are dropped
    tag_a = 8'h21;
    run_nom_a("ign", 9'b010100101, -1);
    @(negedge clk);
    chk_eq("ign_idle", 64'(ctl_a), 64'd0);

    // backpressure: m_ready low from start onward
    tag_a = 8'h5A;
    m_ready_a = 1'b0;
    cnt = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (rd_en_a) cnt++;
      if (k == 6) chk_eq("bp_hold_early", 64'(m_data_a), 64'({8'h5A, 16'h0000, 8'h11}));
      start_a = (k == 0);
    end
    start_a = 1'b0;
    chk_eq("bp_reads", 64'(cnt), 64'd4);
    chk_eq("bp_valid", 64'(m_valid_a), 64'd1);
    chk_eq("bp_hold", 64'(m_data_a), 64'({8'h5A, 16'h0000, 8'h11}));
    chk_eq("bp_busy", 64'(busy_a), 64'd1);
    n = 0;
    got_done = 1'b0;
    for (int k = 0; k < 20 && !got_done; k++) begin
      @(negedge clk);
      m_ready_a = 1'b1;
      if (m_valid_a && m_ready_a) begin
        chk_eq($sformatf("bp_data%0d", n), 64'(m_data_a), 64'({8'h5A, 16'h0000, nom_lo[n+3]}));
        chk_eq($sformatf("bp_last%0d", n), 64'(m_last_a), 64'(n == 3));
        n++;
      end
      if (done_a) got_done = 1'b1;
    end
    chk_eq("bp_beats", 64'(n), 64'd4);
    chk_eq("bp_done", 64'(got_done), 64'd1);

    // reset one cycle after the 2nd beat, then a fresh pass
    tag_a = 8'h77;
    run_nom_a("abort", 9'b000000001, 4);
    @(negedge clk);
    chk_eq("abort_ctl", 64'(ctl_a), 64'd0);
    chk_eq("abort_data", 64'(m_data_a), 64'd0);
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (m_valid_a || busy_a || rd_en_a) cnt++;
    end
    chk_eq("abort_quiet", 64'(cnt), 64'd0);
    tag_a = 8'h3C;
    run_nom_a("fresh", 9'b000000001, -1);

    // single-row pass
    tag_c = 8'hC1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk_eq($sformatf("one_ctl_k%0d", k), 64'(ctl_c), 64'(one_vec[k]));
      if (one_vec[k][3]) chk_eq("one_data", 64'(m_data_c), 64'({8'hC1, 16'h0000, 8'h11}));
      start_c = (k == 0);
    end
    start_c = 1'b0;

    // 8-row instance: plain pass, credit stall, then random ready
    tag_b = 8'h01;
    pass_b("b_plain", 0);
    tag_b = 8'h02;
    pass_b("b_credit", 2);
    for (int p = 0; p < 20; p++) begin
      tag_b = 8'(16 + p);
      pass_b($sformatf("b_rnd%0d", p), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/result_drain.md
# result_drain

Drains the output buffer at the end of a systolic-array pass: on `start` it issues `ROWS` row reads to the output buffer and captures the returned rows. It then streams them to the downstream consumer (activation stage / host DMA) over a valid/ready interface with `m_last` on the final row. A credit-based FIFO lets backpressure stall the buffer reads without dropping rows. It is the RTL consumer side of the output-buffer read sequence that the accelerator test benches currently drive by hand.

## Interface
Parameters:
- `ROWS`, default `ARRAYHEIGHT`: rows drained per pass (≥1).
- `ROW_W`, default `OUTPUT_BUF_DATASIZE*ARRAYWIDTH`: row width in bits.
- `RD_LAT`, default 1: fixed cycles from `buf_rd_en` to valid `buf_rd_data` (1..4).
- `FIFO_DEPTH`, default 4: capture FIFO entries; must be ≥ `RD_LAT`+2.

Ports:
- `clk` in 1: clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a pass; ignored unless the block is IDLE.
- `buf_rd_en` out 1: output-buffer read strobe, one row per asserted cycle (drives `output_buffer_out_en`).
- `buf_rd_data` in `ROW_W`: row returned `RD_LAT` cycles after its strobe (from `out_top`).
- `m_valid` out 1: downstream data valid.
- `m_ready` in 1: downstream ready.
- `m_data` out `ROW_W`: row data, in read order (row 0 first).
- `m_last` out 1: high with row `ROWS`-1.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse when the pass completes.

## Operation
- FSM states:
  - IDLE → ISSUE on `start`.
  - ISSUE → FLUSH after the `ROWS`-th read is issued.
  - FLUSH → DONE when the last beat handshakes (`m_valid & m_ready & m_last`).
  - DONE → IDLE unconditionally after one cycle; `done`=1 only in DONE.
- Read issue happens in ISSUE when `outstanding + occupancy < FIFO_DEPTH`.
  - Both terms are registered values; a same-cycle pop gives no credit.
  - `outstanding` is reads issued whose data is not yet written; `occupancy` is FIFO entry count.
- Read pipeline is a `RD_LAT`-deep shift register of valid bits. When a bit exits, `buf_rd_data` is written into the FIFO.
- FIFO is show-ahead: `m_data` is the head entry and `m_valid` = (occupancy ≠ 0). A pop occurs on `m_valid & m_ready`.
- Write and pop in the same cycle leave occupancy unchanged and preserve order. On a write to an empty FIFO, the data appears on `m_data` the next cycle.
- Issue counter (0..`ROWS`-1) and beat counter: `m_last` = `m_valid` & (beat counter == `ROWS`-1). The beat counter increments on each pop.
- The credit rule makes overflow impossible; no error path.
- `m_data` is held stable while `m_valid & !m_ready`.
- `start` during ISSUE/FLUSH/DONE is dropped, with no side effect.
- `busy` = state ∈ {ISSUE, FLUSH}.

## Timing
- Reset (`rst`=0 at an edge): the FSM goes to IDLE, counters clear, the FIFO empties and pipeline valid bits clear.
  - Outputs: `buf_rd_en`=0, `m_valid`=0, `m_last`=0, `busy`=0, `done`=0, `m_data`=0.
- Reset mid-pass aborts immediately. Read data still returning afterwards is discarded, and the next `start` begins a fresh pass at row 0.
- With `start` high in cycle c and `m_ready` held high:
  - `buf_rd_en` is high in cycles c+1 .. c+`ROWS`.
  - First `m_valid` is in cycle c+`RD_LAT`+2, then 1 row/cycle with no bubbles.
  - `m_last` is in cycle c+`RD_LAT`+`ROWS`+1, and `done` is in cycle c+`RD_LAT`+`ROWS`+2.
- With `m_ready` low, `buf_rd_en` deasserts once `outstanding + occupancy` reaches `FIFO_DEPTH`. It resumes the cycle after the first pop that frees a credit (registered check).
- `start` in the DONE cycle is ignored. The earliest accepted `start` is the cycle after `done`.
- `ROWS`=1: a single read; `m_last` is set on the first and only beat.

## Test plan
- Nominal: `ROWS`=4, `RD_LAT`=1, rows 0x11,0x22,0x33,0x44, `m_ready`=1, `start` in cycle 10.
  - `buf_rd_en` is high in cycles 11–14.
  - `m_valid` is high in cycles 13–16 with data in order; `m_last` is in cycle 16.
  - `done` is in cycle 17, and `busy` is high in cycles 11–16.
- Backpressure: `m_ready`=0 from `start` onward, `FIFO_DEPTH`=4.
  - Exactly 4 `buf_rd_en` cycles occur, then none; `m_data`=row0 is held.
  - When `m_ready` is raised, all 4 rows arrive in order and `done` follows.
- Random `m_ready` (50%) over 20 passes with `ROWS`=8, `RD_LAT`=3.
  - Output matches the read order and exactly one `m_last` per pass.
  - The FIFO never overflows (occupancy assertion ≤4 — `FIFO_DEPTH`=4 ≥ `RD_LAT`+2 is required by the parameter constraint, so 4 is not valid with `RD_LAT`=3 and this run uses `FIFO_DEPTH`=5, occupancy ≤5).
- `start` pulses in the ISSUE, FLUSH and DONE cycles → ignored; exactly `ROWS` reads occur and one `done` per accepted start.
- `rst`=0 for 1 cycle after the 2nd beat of a 4-row pass.
  - Next cycle: all outputs are 0 and stale returning rows do not appear.
  - A following `start` produces rows 0..3 afresh.
- `ROWS`=1 → one read, one beat with `m_last`=1, and `done` 1 cycle later.
